// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int LEN_MIN = 2;
  localparam int LEN_MAX = 32;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } overlap_e;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins, then the increment applies.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q;
    if (inc && (cnt_d != '1)) cnt_d = cnt_d + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial LEN-bit pattern detector with registered match flag and saturating match count.
module seq_detector_param #(
  parameter int                                LEN     = 5,
  parameter logic [seq_det_pkg::LEN_MAX-1:0] PATTERN = 5'b00110,
  parameter int                                OVERLAP = 0,
  parameter int                                CNT_W   = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   en,
  input  logic                                   w,
  input  logic                                   clr_cnt,
  output logic                                   z,
  output logic [CNT_W-1:0]                       match_cnt,
  output logic [seq_det_pkg::clog2p1(LEN)-1:0] fill
);
  import seq_det_pkg::*;

  localparam int FW  = clog2p1(LEN);
  localparam bit OVL = (OVERLAP == int'(seq_det_pkg::OVERLAP));

  if ((LEN < LEN_MIN) || (LEN > LEN_MAX) || ((PATTERN >> LEN) != '0)) begin : g_bad_param
    $error("seq_detector_param: LEN out of range or PATTERN wider than LEN");
  end

  logic [LEN-1:0] win_q, win_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic           z_q;
  logic [LEN-1:0] cand;
  logic           match;

  // Compare against the window as it will look once the incoming bit is shifted in.
  assign cand  = {win_q[LEN-2:0], w};
  assign match = en && (fill_q >= FW'(LEN - 1)) && (cand == PATTERN[LEN-1:0]);

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (en) begin
      win_d = cand;
      if (match && !OVL)              fill_d = '0;
      else if (fill_q != FW'(LEN))    fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q  <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
      z_q    <= match;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (match),
    .q     (match_cnt)
  );

  assign z    = z_q;
  assign fill = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: three detector flavours share one stimulus stream, hand-computed expectations.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0, w = 1'b0, clr_cnt = 1'b0;

  logic       zA, zB, zC;
  logic [7:0] cA, cB;
  logic [1:0] cC;
  logic [2:0] fA, fB, fC;

  always #5 clk = ~clk;

  // A: non-overlap, B: overlap, C: non-overlap with a 2-bit counter
  seq_detector_param #(.LEN(5), .PATTERN(5'b00110), .OVERLAP(0), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .en(en), .w(w), .clr_cnt(clr_cnt),
    .z(zA), .match_cnt(cA), .fill(fA));
  seq_detector_param #(.LEN(5), .PATTERN(5'b00110), .OVERLAP(1), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .en(en), .w(w), .clr_cnt(clr_cnt),
    .z(zB), .match_cnt(cB), .fill(fB));
  seq_detector_param #(.LEN(5), .PATTERN(5'b00110), .OVERLAP(0), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .en(en), .w(w), .clr_cnt(clr_cnt),
    .z(zC), .match_cnt(cC), .fill(fC));

  typedef struct {
    int         idx;
    logic       zA;
    logic [7:0] cA;
    logic [2:0] fA;
    logic       zB;
    logic [7:0] cB;
    logic [2:0] fB;
    logic [1:0] cC;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   vidx   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("zA", e.idx, 32'(zA), 32'(e.zA));
        chk("cntA", e.idx, 32'(cA), 32'(e.cA));
        chk("fillA", e.idx, 32'(fA), 32'(e.fA));
        chk("zB", e.idx, 32'(zB), 32'(e.zB));
        chk("cntB", e.idx, 32'(cB), 32'(e.cB));
        chk("fillB", e.idx, 32'(fB), 32'(e.fB));
        chk("zC", e.idx, 32'(zC), 32'(e.zA));
        chk("cntC", e.idx, 32'(cC), 32'(e.cC));
        chk("fillC", e.idx, 32'(fC), 32'(e.fA));
      end
    end
  end

  // Drive one vector on the falling edge and queue the state expected after the next rising edge.
  task automatic vec(input logic e_en, input logic e_w, input logic e_clr, input logic e_rst,
                     input logic ezA, input int ecA, input int efA,
                     input logic ezB, input int ecB, input int efB, input int ecC);
    exp_t e;
    @(negedge clk);
    reset = e_rst; en = e_en; w = e_w; clr_cnt = e_clr;
    e.idx = vidx; e.zA = ezA; e.cA = 8'(ecA); e.fA = 3'(efA);
    e.zB = ezB; e.cB = 8'(ecB); e.fB = 3'(efB); e.cC = 2'(ecC);
    exp_q.push_back(e);
    vidx++;
  endtask

  initial begin
    // reset state
    vec(0,0,0,1, 0,0,0, 0,0,0, 0);
    // 0,0,1,1,0
    vec(1,0,0,0, 0,0,1, 0,0,1, 0);
    vec(1,0,0,0, 0,0,2, 0,0,2, 0);
    vec(1,1,0,0, 0,0,3, 0,0,3, 0);
    vec(1,1,0,0, 0,0,4, 0,0,4, 0);
    vec(1,0,0,0, 1,1,0, 1,1,5, 1);
    // 0,0,0,1,1,0: leading extra zero
    vec(1,0,0,0, 0,1,1, 0,1,5, 1);
    vec(1,0,0,0, 0,1,2, 0,1,5, 1);
    vec(1,0,0,0, 0,1,3, 0,1,5, 1);
    vec(1,1,0,0, 0,1,4, 0,1,5, 1);
    vec(1,1,0,0, 0,1,5, 0,1,5, 1);
    vec(1,0,0,0, 1,2,0, 1,2,5, 2);
    // 0,0,1,1,0,0,1,1,0: only overlap mode sees the second match
    vec(1,0,0,0, 0,2,1, 0,2,5, 2);
    vec(1,0,0,0, 0,2,2, 0,2,5, 2);
    vec(1,1,0,0, 0,2,3, 0,2,5, 2);
    vec(1,1,0,0, 0,2,4, 0,2,5, 2);
    vec(1,0,0,0, 1,3,0, 1,3,5, 3);
    vec(1,0,0,0, 0,3,1, 0,3,5, 3);
    vec(1,1,0,0, 0,3,2, 0,3,5, 3);
    vec(1,1,0,0, 0,3,3, 0,3,5, 3);
    vec(1,0,0,0, 0,3,4, 1,4,5, 3);
    // 0,0,1,1 then reset mid-sequence
    vec(1,0,0,0, 0,3,5, 0,4,5, 3);
    vec(1,0,0,0, 0,3,5, 0,4,5, 3);
    vec(1,1,0,0, 0,3,5, 0,4,5, 3);
    vec(1,1,0,0, 0,3,5, 0,4,5, 3);
    vec(0,0,0,1, 0,0,0, 0,0,0, 0);
    vec(1,0,0,0, 0,0,1, 0,0,1, 0);
    // full 0,0,1,1,0 after the released 0
    vec(1,0,0,0, 0,0,2, 0,0,2, 0);
    vec(1,0,0,0, 0,0,3, 0,0,3, 0);
    vec(1,1,0,0, 0,0,4, 0,0,4, 0);
    vec(1,1,0,0, 0,0,5, 0,0,5, 0);
    vec(1,0,0,0, 1,1,0, 1,1,5, 1);
    // en toggling between pattern bits; gaps carry garbage w
    vec(0,1,0,0, 0,1,0, 0,1,5, 1);
    vec(1,0,0,0, 0,1,1, 0,1,5, 1);
    vec(0,1,0,0, 0,1,1, 0,1,5, 1);
    vec(1,0,0,0, 0,1,2, 0,1,5, 1);
    vec(0,0,0,0, 0,1,2, 0,1,5, 1);
    vec(1,1,0,0, 0,1,3, 0,1,5, 1);
    vec(0,0,0,0, 0,1,3, 0,1,5, 1);
    vec(1,1,0,0, 0,1,4, 0,1,5, 1);
    vec(0,1,0,0, 0,1,4, 0,1,5, 1);
    vec(1,0,0,0, 1,2,0, 1,2,5, 2);
    // clear counters with no bit
    vec(0,0,1,0, 0,0,0, 0,0,5, 0);
    // six back-to-back matches; clr_cnt on the last completing edge
    for (int k = 1; k <= 6; k++) begin
      int pc, pcc, nc, ncc;
      pc  = k - 1;
      pcc = (k - 1 > 3) ? 3 : k - 1;
      nc  = (k == 6) ? 1 : k;
      ncc = (k == 6) ? 1 : ((k > 3) ? 3 : k);
      vec(1,0,0,0, 0,pc,1, 0,pc,5, pcc);
      vec(1,0,0,0, 0,pc,2, 0,pc,5, pcc);
      vec(1,1,0,0, 0,pc,3, 0,pc,5, pcc);
      vec(1,1,0,0, 0,pc,4, 0,pc,5, pcc);
      vec(1,0,(k == 6),0, 1,nc,0, 1,nc,5, ncc);
    end
    @(negedge clk);
    en = 1'b0; clr_cnt = 1'b0;
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
